// File: rtl/serial_master_port.sv
`default_nettype none
// ============================================================================
// Module   : serial_master_port
// Brief    : Master-side bit-serial bus port: serialises one parallel read or
//            write request and deserialises read data. Optional wait timeout
//            is enabled by defining SMP_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module serial_master_port #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req,
    output logic                  req_ack,
    input  logic                  req_mode,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  done,
    output logic                  err,
    output logic                  busy,
    output logic                  swdata,
    output logic                  smode,
    output logic                  mvalid,
    input  logic                  srdata,
    input  logic                  svalid,
    input  logic                  sready
);
    localparam int c_MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int c_CNT_W = (c_MAX_W > 1) ? $clog2(c_MAX_W) : 1;
    localparam logic [c_CNT_W-1:0] c_ADDR_LAST = c_CNT_W'(ADDR_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_WIDTH - 1);
    // Bit 0 is taken in WAIT_RDATA, so RECV_DATA counts the remaining bits.
    localparam logic [c_CNT_W-1:0] c_RECV_LAST = c_CNT_W'(DATA_WIDTH - 2);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_RDY   = 3'd1,
        S_SEND_ADDR  = 3'd2,
        S_SEND_DATA  = 3'd3,
        S_WAIT_RDATA = 3'd4,
        S_RECV_DATA  = 3'd5,
        S_DONE       = 3'd6
    } state_t;

    state_t                             r_state;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0]   r_tx;
    logic [DATA_WIDTH-2:0]              r_shift;
    logic [DATA_WIDTH-1:0]              r_rdata;
    logic [c_CNT_W-1:0]                 r_bcnt;
    logic                               r_swdata;
    logic                               r_smode;
    logic                               r_mvalid;
    logic                               r_done;
    logic                               r_err;
    logic                               r_busy;
    logic [DATA_WIDTH-1:0]              w_rx_next;
    logic                               w_timeout;

    assign w_rx_next = {srdata, r_shift};

`ifdef SMP_TIMEOUT_EN
    localparam int c_TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_TMO_W-1:0] r_tcnt;
    logic               w_waiting;

    // Only genuine waiting cycles are timed; leaving or entering a wait state clears the count.
    assign w_waiting = ((r_state == S_WAIT_RDY) && !sready) ||
                       ((r_state == S_WAIT_RDATA) && !svalid);
    assign w_timeout = w_waiting && (r_tcnt == c_TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rstn || !w_waiting) begin
            r_tcnt <= '0;
        end else begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_tx     <= '0;
            r_shift  <= '0;
            r_rdata  <= '0;
            r_bcnt   <= '0;
            r_swdata <= 1'b0;
            r_smode  <= 1'b0;
            r_mvalid <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_timeout) begin
                // Abort straight to the done report; rdata keeps its old value.
                r_state  <= S_IDLE;
                r_done   <= 1'b1;
                r_err    <= 1'b1;
                r_mvalid <= 1'b0;
                r_swdata <= 1'b0;
                r_bcnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_busy   <= 1'b0;
                        r_mvalid <= 1'b0;
                        r_swdata <= 1'b0;
                        r_bcnt   <= '0;
                        if (req) begin
                            r_tx    <= {req_wdata, req_addr};
                            r_smode <= req_mode;
                            r_busy  <= 1'b1;
                            r_state <= S_WAIT_RDY;
                        end
                    end
                    S_WAIT_RDY: begin
                        if (sready) begin
                            r_state <= S_SEND_ADDR;
                        end
                    end
                    S_SEND_ADDR: begin
                        r_mvalid <= 1'b1;
                        r_swdata <= r_tx[0];
                        r_tx     <= r_tx >> 1;
                        if (r_bcnt == c_ADDR_LAST) begin
                            r_bcnt  <= '0;
                            r_state <= r_smode ? S_SEND_DATA : S_WAIT_RDATA;
                        end else begin
                            r_bcnt <= r_bcnt + 1'b1;
                        end
                    end
                    S_SEND_DATA: begin
                        r_mvalid <= 1'b1;
                        r_swdata <= r_tx[0];
                        r_tx     <= r_tx >> 1;
                        if (r_bcnt == c_DATA_LAST) begin
                            r_bcnt  <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_bcnt <= r_bcnt + 1'b1;
                        end
                    end
                    S_WAIT_RDATA: begin
                        r_mvalid <= 1'b0;
                        r_swdata <= 1'b0;
                        if (svalid) begin
                            r_shift <= w_rx_next[DATA_WIDTH-1:1];
                            r_state <= S_RECV_DATA;
                        end
                    end
                    S_RECV_DATA: begin
                        if (svalid) begin
                            if (r_bcnt == c_RECV_LAST) begin
                                r_rdata <= w_rx_next;
                                r_bcnt  <= '0;
                                r_state <= S_DONE;
                            end else begin
                                r_shift <= w_rx_next[DATA_WIDTH-1:1];
                                r_bcnt  <= r_bcnt + 1'b1;
                            end
                        end
                    end
                    S_DONE: begin
                        r_done   <= 1'b1;
                        r_mvalid <= 1'b0;
                        r_swdata <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign req_ack = (r_state == S_IDLE);
    assign rdata   = r_rdata;
    assign done    = r_done;
    assign err     = r_err;
    assign busy    = r_busy;
    assign swdata  = r_swdata;
    assign smode   = r_smode;
    assign mvalid  = r_mvalid;

endmodule
`default_nettype wire

// File: tb/tb_serial_master_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_master_port
// Brief    : Self-checking bench for serial_master_port with a transaction-level
//            reference model of the serial bus and a randomising slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_master_port;
    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          req = 1'b0;
    logic          req_mode = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          srdata = 1'b0;
    logic          svalid = 1'b0;
    logic          sready = 1'b0;
    logic          req_ack;
    logic [DW-1:0] rdata;
    logic          done;
    logic          err;
    logic          busy;
    logic          swdata;
    logic          smode;
    logic          mvalid;

    int            n_chk  = 0;
    int            n_fail = 0;
    logic [DW-1:0] m_rdata = '0;

    serial_master_port #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req       (req),
        .req_ack   (req_ack),
        .req_mode  (req_mode),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rdata     (rdata),
        .done      (done),
        .err       (err),
        .busy      (busy),
        .swdata    (swdata),
        .smode     (smode),
        .mvalid    (mvalid),
        .srdata    (srdata),
        .svalid    (svalid),
        .sready    (sready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete transaction. Time index t counts negedges after the accept edge T,
    // so a value seen at t was registered at edge T+t.
    task automatic run_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int rdy_delay, input int lat, input int stall_pct,
                           input int stall_at, input bit no_resp);
        logic [AW+DW-1:0] got = '0;
        int nmv = 0, first_mv = -1, prev_mv = -1, done_at = -1, gaps = 0;
        int t_last_addr = -1, t_last_bit = -1, sent = 0, stall_left = 0;
        bit mode_bad = 0, ack_bad = 0, busy_bad = 0, hold_bad = 0, stalled = 0;
        logic err_seen = 1'b0;
        @(negedge clk);
        check("idle_req_ack", req_ack, 1);
        req = 1'b1; req_mode = wr; req_addr = a; req_wdata = d;
        sready = (rdy_delay == 0); svalid = 1'b0;
        @(negedge clk);
        req = 1'b0; req_mode = 1'($urandom); req_addr = AW'($urandom); req_wdata = DW'($urandom);
        for (int t = 0; t < 400 && done_at < 0; t++) begin
            if (t > 0) @(negedge clk);
            if (busy !== 1'b1) busy_bad = 1;
            if (done === 1'b1) begin
                done_at = t;
                err_seen = err;
            end else if (req_ack !== 1'b0) begin
                ack_bad = 1;
            end
            if ((t_last_bit < 0 || t <= t_last_bit) && rdata !== m_rdata) hold_bad = 1;
            if (mvalid === 1'b1) begin
                if (smode !== wr) mode_bad = 1;
                if (nmv < AW + DW) got[nmv] = swdata;
                if (prev_mv >= 0 && t != prev_mv + 1) gaps++;
                if (first_mv < 0) first_mv = t;
                prev_mv = t;
                nmv++;
                if (nmv == AW) t_last_addr = t;
            end
            if (t == rdy_delay) sready = 1'b1;
            req = (t >= 1 && t <= 8) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_addr = AW'($urandom);
            if (wr || nmv < AW) begin
                svalid = (!wr && no_resp) ? 1'b0 : 1'($urandom_range(0, 1));
                srdata = 1'($urandom);
            end else if (!no_resp && t >= t_last_addr + lat && sent < DW) begin
                if (stall_left > 0) begin
                    svalid = 1'b0;
                    stall_left--;
                end else if (sent == stall_at && !stalled) begin
                    svalid = 1'b0;
                    stall_left = 1;
                    stalled = 1;
                end else if (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) begin
                    svalid = 1'b0;
                end else begin
                    svalid = 1'b1;
                    srdata = d[sent];
                    sent++;
                    if (sent == DW) t_last_bit = t;
                end
            end else begin
                svalid = 1'b0;
                srdata = 1'($urandom);
            end
        end
        svalid = 1'b0;
        req = 1'b0;
        check("done_seen", (done_at >= 0), 1);
        check("first_mvalid_t", first_mv, 2 + rdy_delay);
        check("mvalid_count", nmv, wr ? AW + DW : AW);
        check("mvalid_gaps", gaps, 0);
        check("smode_held", mode_bad, 0);
        check("req_ack_low_busy", ack_bad, 0);
        check("busy_high", busy_bad, 0);
        check("rdata_hold", hold_bad, 0);
        if (wr) begin
            check("wr_bits", got, {d, a});
            check("wr_done_t", done_at, 22 + rdy_delay);
            check("wr_err", err_seen, 0);
        end else begin
            check("rd_addr_bits", got[AW-1:0], a);
            if (no_resp) begin
`ifdef SMP_TIMEOUT_EN
                check("tmo_done_t", done_at, t_last_addr + 255);
`endif
                check("tmo_err", err_seen, 1);
                check("tmo_rdata", rdata, m_rdata);
            end else begin
                m_rdata = d;
                check("rd_done_t", done_at, t_last_bit + 2);
                check("rd_err", err_seen, 0);
                check("rd_rdata", rdata, d);
            end
        end
        @(negedge clk);
        check("post_done_low", done, 0);
        check("post_busy_low", busy, 0);
        check("post_req_ack", req_ack, 1);
    endtask

    initial begin
        int n_done;
        repeat (3) @(negedge clk);
        check("reset_outputs", {swdata, smode, mvalid, done, err, busy, rdata}, 0);
        check("reset_req_ack", req_ack, 1);
        rstn = 1'b1;

        // Directed write and read from the reference sequences.
        run_txn(1'b1, 12'h0A5, 8'h3C, 0, 0, 0, -1, 1'b0);
        run_txn(1'b0, 12'h123, 8'h5A, 0, 3, 0, -1, 1'b0);
        // sready held low 5 cycles after accept.
        run_txn(1'b1, AW'($urandom), DW'($urandom), 5, 0, 0, -1, 1'b0);
        // Two-cycle svalid gap between bits 3 and 4.
        run_txn(1'b0, AW'($urandom), 8'hA7, 0, 1, 0, 4, 1'b0);

        // Reset in the middle of SEND_ADDR.
        @(negedge clk);
        req = 1'b1; req_mode = 1'b1; req_addr = 12'h5C3; req_wdata = 8'h96; sready = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_mvalid", mvalid, 1);
        rstn = 1'b0;
        @(negedge clk);
        check("rst_mvalid", mvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rdata", rdata, 0);
        m_rdata = '0;
        rstn = 1'b1;
        n_done = 0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) n_done++;
        end
        check("rst_no_done", n_done, 0);
        run_txn(1'b1, AW'($urandom), DW'($urandom), 0, 0, 0, -1, 1'b0);

        // Randomised mix of transactions with random stalls.
        for (int i = 0; i < 8; i++) begin
            run_txn(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 4), 30, -1, 1'b0);
        end

`ifdef SMP_TIMEOUT_EN
        run_txn(1'b0, AW'($urandom), DW'($urandom), 0, 0, 0, -1, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
